// File: rtl/mdu_unit_if.sv
// E-stage issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the master side and mdu_unit consumes the slave side.
interface mdu_unit_if;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdop, A, B, req, input busy, hi, lo);
  modport slave  (input start, mdop, A, B, req, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO; the result is computed at issue and committed after N cycles.
// Optional macro MDU_MADD_EN adds madd/maddu/msub with 64-bit accumulate into HI/LO.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic               pend_we_q;
  logic [31:0]        hi_q, lo_q;

  logic               is_mul, is_div, is_sgn;
`ifdef MDU_MADD_EN
  logic               is_acc, is_sub;
  logic [63:0]        acc_sum;
`endif
  logic               accept, issue, busy, commit, b_zero;
  logic [63:0]        a_ext, b_ext, prod;
  logic signed [32:0] a33, b33;
  logic [31:0]        quo, rem;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    is_mul = 1'b0;
    is_div = 1'b0;
    is_sgn = 1'b0;
`ifdef MDU_MADD_EN
    is_acc = 1'b0;
    is_sub = 1'b0;
`endif
    case (bus.mdop)
      OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; is_sgn = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_sgn = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept = bus.start & ~bus.req & (state_q == IDLE);
  assign issue  = accept & (is_mul | is_div);
  assign b_zero = (bus.B == 32'd0);

  // Extending by signedness lets one multiplier and one divider serve both flavours.
  assign a_ext = {{32{is_sgn & bus.A[31]}}, bus.A};
  assign b_ext = {{32{is_sgn & bus.B[31]}}, bus.B};
  assign prod  = a_ext * b_ext;
  assign a33   = {is_sgn & bus.A[31], bus.A};
  assign b33   = b_zero ? 33'sd1 : {is_sgn & bus.B[31], bus.B};
  assign quo   = 32'(a33 / b33);
  assign rem   = 32'(a33 % b33);

`ifdef MDU_MADD_EN
  assign acc_sum = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
  assign pend_d  = is_acc ? acc_sum : (is_mul ? prod : {rem, quo});
`else
  assign pend_d  = is_mul ? prod : {rem, quo};
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (issue) begin
        state_d = RUN;
        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    commit = (state_q == RUN) && (cnt_q == CNT_W'(1));
  end

  // Divide by zero still occupies the unit but leaves HI/LO untouched at commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= '0;
      pend_we_q <= 1'b0;
    end else if (issue) begin
      pend_q    <= pend_d;
      pend_we_q <= ~(is_div & b_zero);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit && pend_we_q) begin
      {hi_q, lo_q} <= pend_q;
    end else if (accept && bus.mdop == OP_MTHI) begin
      hi_q <= bus.A;
    end else if (accept && bus.mdop == OP_MTLO) begin
      lo_q <= bus.A;
    end
  end

  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written corner sequences and
// randomized operations checked against an arithmetic reference model of HI/LO.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  always #5 clk = ~clk;

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: HI/LO from plain 64-bit arithmetic; returns the expected busy length.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic rq, output int n);
    longint      sa, sb;
    logic [63:0] p;
    n = 0;
    if (rq) return;
    case (op)
      4'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {mhi, mlo} = p; n = MC; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; n = MC; end
      4'd3, 4'd4: begin
        n = DC;
        if (b != 32'd0) begin
          sa = (op == 4'd3) ? longint'($signed(a)) : longint'({32'd0, a});
          sb = (op == 4'd3) ? longint'($signed(b)) : longint'({32'd0, b});
          mlo = 32'(sa / sb);
          mhi = 32'(sa % sb);
        end
      end
      4'd5: mhi = a;
      4'd6: mlo = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {mhi, mlo} = {mhi, mlo} + p; n = MC; end
      4'd8: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = {mhi, mlo} + p; n = MC; end
      4'd9: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {mhi, mlo} = {mhi, mlo} - p; n = MC; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op, then count busy cycles; poke_mode 1 = stray mult start, 2 = req, at cycle poke_at.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input int poke_at, input int poke_mode, output int cycles);
    bus.start = 1'b1; bus.mdop = op; bus.A = a; bus.B = b; bus.req = rq;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.req = 1'b0; bus.mdop = 4'd0;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      if (cycles == poke_at) begin
        if (poke_mode == 1) begin
          bus.start = 1'b1; bus.mdop = 4'd1; bus.A = 32'd3; bus.B = 32'd3;
        end else begin
          bus.req = 1'b1;
        end
      end
      cycles++;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.req = 1'b0; bus.mdop = 4'd0;
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rq);
    int exp_n, n;
    model_apply(op, a, b, rq, exp_n);
    run_op(op, a, b, rq, -1, 0, n);
    check({name, " cycles"}, 64'(n), 64'(exp_n));
    check({name, " hilo"}, {bus.hi, bus.lo}, {mhi, mlo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dummy;
    logic [3:0] op;
    logic [31:0] ra, rb;

    vecs[0]  = '{4'd1, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, MC};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[4]  = '{4'd4, 32'd100,      32'd7,        1'b0, 32'h00000002, 32'h0000000E, DC};
    vecs[5]  = '{4'd1, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, MC};
    vecs[6]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[7]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, DC};
    vecs[8]  = '{4'd5, 32'h12345678, 32'd0,        1'b0, 32'h12345678, 32'h80000000, 0};
    vecs[9]  = '{4'd6, 32'h00000009, 32'd0,        1'b0, 32'h12345678, 32'h00000009, 0};
    vecs[10] = '{4'd1, 32'd3,        32'd3,        1'b1, 32'h12345678, 32'h00000009, 0};
    vecs[11] = '{4'd12, 32'd5,       32'd5,        1'b0, 32'h12345678, 32'h00000009, 0};

    bus.start = 1'b0; bus.mdop = 4'd0; bus.A = 32'd0; bus.B = 32'd0; bus.req = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Directed table; consecutive entries 8/9 exercise mthi then mtlo in the next cycle.
    for (int i = 0; i < 12; i++) begin
      model_apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq, dummy);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq, -1, 0, n);
      check($sformatf("vec%0d cycles", i), 64'(n), 64'(vecs[i].exp_cyc));
      check($sformatf("vec%0d hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
    end

    // Divide by zero keeps HI/LO; a stray mult start while busy is ignored.
    check_op("mthi 11", 4'd5, 32'h11, 32'd0, 1'b0);
    check_op("mtlo 22", 4'd6, 32'h22, 32'd0, 1'b0);
    run_op(4'd4, 32'd5, 32'd0, 1'b0, 2, 1, n);
    check("divu0 cycles", 64'(n), 64'(DC));
    check("divu0 hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});
    @(posedge clk); #1;
    check("divu0 no stray issue", 64'(bus.busy), 64'd0);

    // req during RUN does not cancel the committed operation.
    model_apply(4'd2, 32'h10000, 32'h30000, 1'b0, dummy);
    run_op(4'd2, 32'h10000, 32'h30000, 1'b0, 1, 2, n);
    check("req in run cycles", 64'(n), 64'(MC));
    check("req in run hilo", {bus.hi, bus.lo}, {32'h00000003, 32'h00000000});

`ifdef MDU_MADD_EN
    check_op("mthi 0", 4'd5, 32'd0, 32'd0, 1'b0);
    check_op("mtlo ff", 4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    check_op("madd 1x1", 4'd7, 32'd1, 32'd1, 1'b0);
    check("madd const", {bus.hi, bus.lo}, {32'h1, 32'h0});
    check_op("msub 2x1", 4'd9, 32'd2, 32'd1, 1'b0);
    check("msub const", {bus.hi, bus.lo}, {32'h0, 32'hFFFFFFFE});
    check_op("maddu", 4'd8, 32'hFFFFFFFF, 32'd2, 1'b0);
`else
    run_op(4'd7, 32'd1, 32'd1, 1'b0, -1, 0, n);
    check("madd disabled cycles", 64'(n), 64'd0);
    check("madd disabled hilo", {bus.hi, bus.lo}, {mhi, mlo});
`endif

    // Randomized back-to-back operations against the model.
    for (int i = 0; i < 60; i++) begin
`ifdef MDU_MADD_EN
      op = 4'($urandom_range(1, 9));
`else
      op = 4'($urandom_range(1, 6));
`endif
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      check_op($sformatf("rnd%0d op%0d", i, op), op, ra, rb, $urandom_range(0, 7) == 0);
    end

    // Reset between edges in cycle 3 of a mult clears everything; nothing commits later.
    check_op("pre-reset mtlo", 4'd6, 32'hABCD, 32'd0, 1'b0);
    bus.start = 1'b1; bus.mdop = 4'd1; bus.A = 32'd5; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mdop = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async reset busy", 64'(bus.busy), 64'd0);
    check("async reset hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post reset busy", 64'(bus.busy), 64'd0);
    check("post reset hilo", {bus.hi, bus.lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
